// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage core: resolves memory wait, multi-cycle EX,
// taken-branch and load-use hazards, and counts stall cycles (saturating).
module pipeline_control #(
    parameter int MC_LATENCY = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ready,
    input  logic                 i_ex_multicycle,
    input  logic                 i_branch_taken,
    input  logic                 i_load_use,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_id_ex_en,
    output logic                 o_ex_mem_en,
    output logic                 o_mem_wb_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_flush,
    output logic                 o_ex_mem_flush,
    output logic                 o_mc_busy,
    output logic [CNT_WIDTH-1:0] o_stall_count
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    localparam bit         MC_MULTI = (MC_LATENCY > 1);
    localparam logic [3:0] MC_INIT  = 4'(MC_LATENCY - 1);

    state_t               state_q, state_d;
    logic [3:0]           mc_cnt_q, mc_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 mem_stall_s;

    assign mem_stall_s = i_mem_req & ~i_mem_ready;

    // Next-state and control decode, highest-priority hazard first.
    always_comb begin
        state_d        = state_q;
        mc_cnt_d       = mc_cnt_q;
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_mc_busy      = 1'b0;
        if (rst) begin
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
        end else if (mem_stall_s) begin
            // Full freeze; a held multi-cycle op still occupies EX.
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
            o_mc_busy   = (state_q == ST_MC_WAIT);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_ex_multicycle && MC_MULTI) begin
                        o_pc_en        = 1'b0;
                        o_if_id_en     = 1'b0;
                        o_id_ex_en     = 1'b0;
                        o_ex_mem_flush = 1'b1;
                        o_mc_busy      = 1'b1;
                        state_d        = ST_MC_WAIT;
                        mc_cnt_d       = MC_INIT;
                    end else if (i_branch_taken) begin
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (i_load_use) begin
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                    end else begin
                        o_mc_busy = 1'b0;
                    end
                end
                ST_MC_WAIT: begin
                    o_mc_busy = 1'b1;
                    if (mc_cnt_q > 4'd1) begin
                        o_pc_en        = 1'b0;
                        o_if_id_en     = 1'b0;
                        o_id_ex_en     = 1'b0;
                        o_ex_mem_flush = 1'b1;
                        mc_cnt_d       = mc_cnt_q - 4'd1;
                    end else begin
                        state_d  = ST_RUN;
                        mc_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d  = ST_RUN;
                    mc_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_comb begin
        if (!o_pc_en && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, multi-cycle countdown and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mc_cnt_q    <= 4'd0;
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_count = stall_cnt_q;

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central stall/flush sequencer for the 5-stage core. It drives the write-enable and bubble-insert (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. It resolves four hazard sources: data-memory wait, multi-cycle EX ops, taken branches and load-use. It also keeps a saturating stall-cycle performance counter.

Parameters:
MC_LATENCY, 3, total cycles a multi-cycle EX op (mul/div) occupies EX; legal range is 1..15, and 1 means no stall.
CNT_WIDTH, 32, width of the stall performance counter.

Ports:
clk  input  1  core clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
i_mem_req  input  1  MEM stage has an active load/store
i_mem_ready  input  1  data memory completes the access this cycle
i_ex_multicycle  input  1  instruction in EX is a multi-cycle op
i_branch_taken  input  1  branch/jump in EX resolved taken; PC mux selects target
i_load_use  input  1  hazard unit: ID instruction depends on the load in EX
o_pc_en  output  1  PC register write enable
o_if_id_en  output  1  IF/ID write enable
o_id_ex_en  output  1  ID/EX write enable
o_ex_mem_en  output  1  EX/MEM write enable
o_mem_wb_en  output  1  MEM/WB write enable
o_if_id_flush  output  1  when 1 with enable, IF/ID loads NOP
o_id_ex_flush  output  1  when 1 with enable, ID/EX loads NOP
o_ex_mem_flush  output  1  when 1 with enable, EX/MEM loads NOP
o_mc_busy  output  1  multi-cycle op is holding EX this cycle
o_stall_count  output  CNT_WIDTH  cycles with o_pc_en=0 since reset, saturating

Behaviour:
State and reset
- States: RUN, MC_WAIT. The 4-bit counter mc_cnt is used only in MC_WAIT.
- While rst=1: state=RUN, mc_cnt=0, o_stall_count=0. All enables, flushes and o_mc_busy are forced to 0 combinationally.
- Reset mid-operation aborts MC_WAIT immediately. The first cycle after deassertion is evaluated as RUN.
- Outputs are combinational from (state, mc_cnt, inputs). There is zero-cycle latency from hazard input to control.
- Default, with no hazard: all enables=1 and all flushes=0.

Priority per cycle, highest first
- 1) Memory stall, when i_mem_req=1 and i_mem_ready=0.
  - All enables=0 and all flushes=0 (full freeze).
  - State and mc_cnt are held.
  - All other inputs are ignored.
- 2) Multi-cycle entry: state=RUN, i_ex_multicycle=1, MC_LATENCY>1.
  - o_pc_en=o_if_id_en=o_id_ex_en=0.
  - o_ex_mem_en=1 with o_ex_mem_flush=1 (bubble); o_mem_wb_en=1.
  - o_mc_busy=1. Next state is MC_WAIT with mc_cnt=MC_LATENCY-1.
- 2b) In MC_WAIT, i_ex_multicycle is ignored.
  - If mc_cnt>1: same controls as entry, and mc_cnt decrements.
  - If mc_cnt==1 (release cycle): default controls, o_mc_busy=1, next state RUN, mc_cnt=0.
  - Net effect: the op spends exactly MC_LATENCY cycles in EX.
- 3) Taken branch (RUN only): o_pc_en=1 and all enables=1.
  - o_if_id_flush=1 and o_id_ex_flush=1.
  - Overrides i_load_use, because the dependent instruction is squashed.
- 4) Load-use (RUN only): o_pc_en=0 and o_if_id_en=0.
  - o_id_ex_en=1 with o_id_ex_flush=1; EX/MEM and MEM/WB enabled.
  - Gives a one-cycle bubble. The hazard unit deasserts i_load_use next cycle.

Boundary rules
- A branch asserted during a memory stall is held in EX and takes effect on the first non-stall cycle.
- i_branch_taken together with i_ex_multicycle is illegal. The multi-cycle op wins, and the bench flags it with an assertion.
- MC_LATENCY=1 never enters MC_WAIT.
- Stall counter increments on every non-reset cycle with o_pc_en=0, and saturates at all-ones without wrapping.

Test Plan:
- Reset: rst=1 for 3 cycles with random inputs -> all enables/flushes 0 and o_stall_count=0. After release with idle inputs -> all enables 1, flushes 0.
- Multi-cycle, MC_LATENCY=3: i_ex_multicycle=1 for 3 cycles.
  - Required: cycles 0–1 have o_pc_en=0 and o_ex_mem_flush=1; cycle 2 has all enables 1 and o_mc_busy=1; cycle 3 has o_mc_busy=0.
  - o_stall_count=2.
- Memory stall inside MC_WAIT: i_mem_req=1, i_mem_ready=0 for 4 cycles starting at cycle 1.
  - Required: all enables 0 for those cycles, mc_cnt frozen, release occurs 4 cycles later.
  - o_stall_count=6.
- Branch versus load-use: i_branch_taken=1 and i_load_use=1 in the same cycle.
  - Required: o_pc_en=1, o_if_id_flush=1, o_id_ex_flush=1, o_stall_count unchanged.
- Load-use alone for 1 cycle -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1. Next cycle -> default.
- Counter saturation, CNT_WIDTH=4: hold a memory stall for 20 cycles -> o_stall_count reaches 15 and stays at 15. Assert rst mid-stall -> 0.
